word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
//   Parallel-in/serial-out reader for a WIDTH-bit register word. Accepts one
//   parallel word per valid/ready transfer, then drives it out one bit per
//   accepted serial beat with its own valid/ready handshake. Sits between
//   register storage (16-bit words) and bit-serial links or debug readout.
// PARAMETERS
//   WIDTH      16   word width in bits; legal range 2..64
//   MSB_FIRST  1    1: bit WIDTH-1 is shifted out first; 0: bit 0 is shifted out first
// PORTS
//   clk_i        in   1      single clock, rising edge
//   rst_n_i      in   1      reset, asynchronous assert, active-low
//   data_i       in   WIDTH  parallel word; sampled only on an accept
//   valid_i      in   1      parallel word valid
//   ready_o      out  1      serializer can accept a word (IDLE only)
//   ser_o        out  1      current serial bit
//   ser_valid_o  out  1      ser_o is valid
//   ser_ready_i  in   1      sink takes ser_o on this edge
//   last_o       out  1      ser_o is the final bit of the word
//   busy_o       out  1      a word is being shifted out
// BEHAVIOUR
//   Interface: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
//   Reset (asserts immediately, no clock needed): state=IDLE, shift reg=0, count=0.
//     Output values in reset: ready_o=1, ser_o=0, ser_valid_o=0, last_o=0,
//     busy_o=0.
//   States: IDLE, SHIFT.
//   IDLE: ready_o=1, ser_valid_o=0, ser_o=0.
//     Accept = valid_i & ready_o at a rising edge.
//     On accept: load data_i into the shift reg, set count=0, and go to SHIFT.
//   SHIFT: ready_o=0, busy_o=1, ser_valid_o=1.
//     ser_o is the current head bit: MSB when MSB_FIRST=1, LSB otherwise.
//     valid_i is ignored; data_i is not sampled.
//   Beat = ser_valid_o & ser_ready_i.
//     On a beat: shift the reg by one toward the head, zero-fill the tail,
//     and increment count.
//     No beat (ser_ready_i=0): hold ser_o, the reg and count. ser_valid_o
//     stays 1 and is never withdrawn.
//   last_o = SHIFT & (count == WIDTH-1).
//     A beat while last_o=1 returns the block to IDLE. The counter does not
//     wrap past WIDTH-1.
//   Latency: first bit valid 1 cycle after the accept edge.
//     With ser_ready_i held at 1: bits appear on WIDTH consecutive cycles,
//     then 1 IDLE cycle before the next accept.
//     Throughput: 1 word per WIDTH+1 cycles.
//   Count width: $clog2(WIDTH) bits, unsigned compare against WIDTH-1.
//   Reset mid-word: the word in flight is discarded; no partial completion.
//     Outputs take their reset values asynchronously.
//   Simultaneous events:
//     valid_i during the final beat is not accepted, because ready_o=0.
//     ser_ready_i in IDLE is ignored.
// STRUCTURE
//   Shared package hack_pkg holds: WORD_W=16, the state encoding
//   (ST_IDLE=1'b0, ST_SHIFT=1'b1), and a CNT_W function (clog2).
//   Sub-module piso_shift_reg (WIDTH, MSB_FIRST) contains only the datapath:
//     ports: clk_i, rst_n_i, load_i, shift_i, data_i, head_o.
//     load_i has priority over shift_i.
//   The top level holds the FSM, the counter and the handshake outputs.
// TESTING
//   1. Reset check: assert rst_n_i=0 with random inputs
//      -> ready_o=1, ser_valid_o=0, ser_o=0, busy_o=0, last_o=0, with no
//      clock edge needed.
//   2. Single word: data_i=16'hA5C3, MSB_FIRST=1, ser_ready_i=1
//      -> ser_o sequence 1010_0101_1100_0011 on 16 cycles.
//      -> last_o high only on the 16th bit; ready_o=1 on cycle 17.
//   3. Same word with MSB_FIRST=0
//      -> ser_o sequence 1100_0011_1010_0101 (LSB first).
//   4. Backpressure: ser_ready_i low for 3 cycles at bit 5 of 16'hFF00
//      -> ser_o and ser_valid_o held stable; the sequence resumes unchanged
//      with 16 total beats.
//   5. Overlap: valid_i held high with data_i changing during SHIFT
//      -> no accept until IDLE; the new word is taken on the first IDLE edge.
//   6. Mid-word reset: pulse rst_n_i low after bit 7
//      -> outputs return to reset values at once; the next word
//      (16'h0001) serializes cleanly from bit 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the word serializer: default word width, FSM
// state encoding and the counter-width helper.
package hack_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to count beats 0..width-1; never less than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel-word input and serial-bit output bundle of the word serializer.
// Both sides use valid/ready: a transfer happens on a rising edge where
// valid and ready are both 1; valid, once raised, is held with its data
// until that transfer. The state field exposes the FSM for observation.
interface word_serializer_if
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             ser_o;
    logic             ser_valid_o;
    logic             ser_ready_i;
    logic             last_o;
    logic             busy_o;
    state_t           state;

    modport master (
        output data_i, valid_i, ser_ready_i,
        input  ready_o, ser_o, ser_valid_o, last_o, busy_o, state
    );

    modport slave (
        input  data_i, valid_i, ser_ready_i,
        output ready_o, ser_o, ser_valid_o, last_o, busy_o, state
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register; the head bit is the next bit out.
// A load overrides a shift issued on the same edge.
module piso_shift_reg #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             head_o
);
    logic [WIDTH-1:0] sreg_q;

    generate
        if (MSB_FIRST) begin : g_msb
            // Load a word or move it one place toward the MSB, zero-filling bit 0.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)     sreg_q <= '0;
                else if (load_i)  sreg_q <= data_i;
                else if (shift_i) sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
            end
            assign head_o = sreg_q[WIDTH-1];
        end else begin : g_lsb
            // Load a word or move it one place toward the LSB, zero-filling the MSB.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)     sreg_q <= '0;
                else if (load_i)  sreg_q <= data_i;
                else if (shift_i) sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
            end
            assign head_o = sreg_q[0];
        end
    endgenerate
endmodule

// File: rtl/word_serializer.sv
// Word serializer top: accepts one parallel word in IDLE, then shifts it out
// one bit per serial beat. Holds the FSM, the beat counter and handshakes.
module word_serializer
    import hack_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    word_serializer_if.slave  bus
);
    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] count_q;
    logic          accept;
    logic          beat;
    logic          at_last;
    logic          head;

    assign accept  = bus.valid_i & (state_q == ST_IDLE);
    assign beat    = bus.ser_ready_i & (state_q == ST_SHIFT);
    assign at_last = (state_q == ST_SHIFT) & (count_q == LAST_CNT);

    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sreg (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .load_i (accept),
        .shift_i(beat),
        .data_i (bus.data_i),
        .head_o (head)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: enter SHIFT on an accept, leave on the beat of the final bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)          state_d = ST_SHIFT;
            ST_SHIFT: if (beat && at_last) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Beat counter: cleared on accept and after the final beat, never wraps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)              count_q <= '0;
        else if (accept)           count_q <= '0;
        else if (beat && at_last)  count_q <= '0;
        else if (beat)             count_q <= count_q + 1'b1;
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        bus.ready_o     = (state_q == ST_IDLE);
        bus.busy_o      = (state_q == ST_SHIFT);
        bus.ser_valid_o = (state_q == ST_SHIFT);
        bus.ser_o       = (state_q == ST_SHIFT) & head;
        bus.last_o      = at_last;
        bus.state       = state_q;
    end
endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: an MSB-first and an LSB-first instance share
// the same stimulus and are compared every cycle against a bit-queue model.
module tb_word_serializer;
    import hack_pkg::*;

    localparam int W = WORD_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         valid     = 1'b0;
    logic [W-1:0] data      = '0;
    logic         ser_ready = 1'b0;

    word_serializer_if #(.WIDTH(W)) bus_m ();
    word_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.valid_i     = valid;
    assign bus_m.data_i      = data;
    assign bus_m.ser_ready_i = ser_ready;
    assign bus_l.valid_i     = valid;
    assign bus_l.data_i      = data;
    assign bus_l.ser_ready_i = ser_ready;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_m)
    );
    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_l)
    );

    // ---------------- reference model ----------------
    // Pending bits of the word in flight, in transmission order; an empty
    // queue means the serializer is idle and ready for a word.
    bit           q_m[$];
    bit           q_l[$];
    logic [W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_m.delete();
            q_l.delete();
            exp_q.delete();
        end else if (q_m.size() == 0) begin
            if (valid) begin
                exp_q.push_back(data);
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(data[W-1-i]);
                    q_l.push_back(data[i]);
                end
            end
        end else if (ser_ready) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [W-1:0] raw_m, raw_l, word_m, word_l;
    int           beats_m, beats_l, words_done;

    task automatic clear_capture();
        beats_m = 0; beats_l = 0; words_done = 0;
    endtask

    task automatic check_outputs();
        check_eq("m_ready",     bus_m.ready_o,     q_m.size() == 0);
        check_eq("m_busy",      bus_m.busy_o,      q_m.size() != 0);
        check_eq("m_ser_valid", bus_m.ser_valid_o, q_m.size() != 0);
        check_eq("m_ser",       bus_m.ser_o,       (q_m.size() != 0) ? q_m[0] : 1'b0);
        check_eq("m_last",      bus_m.last_o,      q_m.size() == 1);
        check_eq("m_state",     bus_m.state,       (q_m.size() != 0) ? ST_SHIFT : ST_IDLE);
        check_eq("l_ready",     bus_l.ready_o,     q_l.size() == 0);
        check_eq("l_busy",      bus_l.busy_o,      q_l.size() != 0);
        check_eq("l_ser_valid", bus_l.ser_valid_o, q_l.size() != 0);
        check_eq("l_ser",       bus_l.ser_o,       (q_l.size() != 0) ? q_l[0] : 1'b0);
        check_eq("l_last",      bus_l.last_o,      q_l.size() == 1);
        check_eq("l_state",     bus_l.state,       (q_l.size() != 0) ? ST_SHIFT : ST_IDLE);
    endtask

    // Record the beat that the coming rising edge will perform.
    task automatic capture();
        logic [W-1:0] exp_w;
        if (bus_m.ser_valid_o && ser_ready) begin
            raw_m = {raw_m[W-2:0], bus_m.ser_o};
            beats_m++;
        end
        if (bus_l.ser_valid_o && ser_ready) begin
            raw_l = {raw_l[W-2:0], bus_l.ser_o};
            beats_l++;
        end
        if (bus_m.ser_valid_o && ser_ready && bus_m.last_o) begin
            check_eq("sb_pending", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check_eq("sb_word_m", raw_m, exp_w);
                check_eq("sb_word_l", {<<{raw_l}}, exp_w);
            end
            word_m = raw_m;
            word_l = raw_l;
            words_done++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [W-1:0] d, input logic sr);
        @(negedge clk);
        check_outputs();
        valid     = v;
        data      = d;
        ser_ready = sr;
        capture();
    endtask

    // Reset asserted between clock edges with random inputs; outputs must
    // settle without any edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        valid     = 1'($urandom_range(0, 1));
        data      = W'($urandom);
        ser_ready = 1'($urandom_range(0, 1));
        rst_n     = 1'b0;
        #1;
        check_eq("rst_ready_m",     bus_m.ready_o,     1);
        check_eq("rst_ser_valid_m", bus_m.ser_valid_o, 0);
        check_eq("rst_ser_m",       bus_m.ser_o,       0);
        check_eq("rst_busy_m",      bus_m.busy_o,      0);
        check_eq("rst_last_m",      bus_m.last_o,      0);
        check_eq("rst_ready_l",     bus_l.ready_o,     1);
        check_eq("rst_ser_valid_l", bus_l.ser_valid_o, 0);
        check_eq("rst_ser_l",       bus_l.ser_o,       0);
        check_eq("rst_busy_l",      bus_l.busy_o,      0);
        check_eq("rst_last_l",      bus_l.last_o,      0);
        clear_capture();
        @(negedge clk);
        check_outputs();
        valid     = 1'b0;
        ser_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] d_last;
        logic         sr;
        int           stall;

        raw_m = '0; raw_l = '0; word_m = '0; word_l = '0;
        clear_capture();
        do_reset();

        // Single word A5C3, sink always ready: 16 bits then ready again.
        clear_capture();
        step(1'b1, 16'hA5C3, 1'b1);
        for (int i = 0; i < W + 1; i++) step(1'b0, W'($urandom), 1'b1);
        check_eq("a5c3_ready_c17", bus_m.ready_o, 1);
        check_eq("a5c3_beats",     beats_m, W);
        check_eq("a5c3_msb_seq",   raw_m, 16'hA5C3);
        check_eq("a5c3_lsb_seq",   raw_l, 16'hC3A5);
        check_eq("a5c3_words",     words_done, 1);

        // Backpressure: sink stalls 3 cycles when bit 5 is presented.
        clear_capture();
        stall = 0;
        step(1'b1, 16'hFF00, 1'b1);
        for (int i = 0; i < 40 && beats_m < W; i++) begin
            if (beats_m == 5 && stall < 3) begin sr = 1'b0; stall++; end
            else sr = 1'b1;
            step(1'b0, W'($urandom), sr);
        end
        step(1'b0, '0, 1'b1);
        check_eq("bp_beats",   beats_m, W);
        check_eq("bp_stalls",  stall, 3);
        check_eq("bp_msb_seq", raw_m, 16'hFF00);
        check_eq("bp_lsb_seq", raw_l, 16'h00FF);

        // Overlap: valid stays high with changing data during the shift.
        clear_capture();
        step(1'b1, 16'h1234, 1'b1);
        d_last = '0;
        for (int i = 0; i < W + 1; i++) begin
            d_last = W'($urandom);
            step(1'b1, d_last, 1'b1);
        end
        for (int i = 0; i < W + 2; i++) step(1'b0, W'($urandom), 1'b1);
        check_eq("ovl_words",  words_done, 2);
        check_eq("ovl_second", word_m, d_last);

        // Mid-word reset after bit 7, then a clean 0001 word.
        clear_capture();
        step(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 20 && beats_m < 8; i++) step(1'b0, '0, 1'b1);
        check_eq("mid_beats", beats_m, 8);
        do_reset();
        step(1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < W + 1; i++) step(1'b0, '0, 1'b1);
        check_eq("post_rst_words", words_done, 1);
        check_eq("post_rst_msb",   word_m, 16'h0001);
        check_eq("post_rst_lsb",   word_l, 16'h8000);

        // Random traffic on both sides.
        for (int i = 0; i < 500; i++)
            step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 3 * W; i++) step(1'b0, '0, 1'b1);
        check_eq("rand_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
